idex_hazard_ctrl: RTL and testbench

Hazard and stall controller that drives the ID/EX stage register's Flush input and gates PC and IF/ID writes.
- Detects load-use hazards and inserts one bubble.
- Holds decode for a fixed number of cycles while a multi-cycle op (mult/div) occupies EX.
- Flushes IF/ID on a taken branch resolved in decode.
- Sits between the decode stage and the IF/ID, PC and ID/EX registers.

---
 rtl/idex_hazard_ctrl_pkg.sv | 13 +
 rtl/idex_hazard_ctrl_if.sv | 33 +++
 rtl/idex_hazard_ctrl_mc_timer.sv | 30 +++
 rtl/idex_hazard_ctrl.sv | 105 ++++++++++
 tb/tb_idex_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/idex_hazard_ctrl_pkg.sv
// Shared constants and FSM encoding for the ID/EX hazard controller.
// The default multi-cycle latency is shared with the mult/div unit.
package hazard_pkg;

    typedef enum logic [0:0] {
        HZ_IDLE    = 1'b0,
        HZ_MC_BUSY = 1'b1
    } hz_state_t;

    localparam int REG_ZERO             = 0;
    localparam int HZ_MC_LATENCY_DEF    = 32;

endpackage

// File: rtl/idex_hazard_ctrl_if.sv
// Decode-side request and pipeline-control bundle for idex_hazard_ctrl.
// master = pipeline/decode side, slave = hazard controller.
interface idex_hazard_ctrl_if #(parameter int REG_ADDR_W = 5);

    logic                  ID_Valid;
    logic [REG_ADDR_W-1:0] ID_Rs;
    logic [REG_ADDR_W-1:0] ID_Rt;
    logic                  ID_UsesRs;
    logic                  ID_UsesRt;
    logic                  ID_IsMultiCycle;
    logic                  ID_BranchTaken;
    logic                  EX_MemRead;
    logic [REG_ADDR_W-1:0] EX_DestReg;
    logic                  PC_Write;
    logic                  IFID_Write;
    logic                  IFID_Flush;
    logic                  IDEX_Flush;
    logic                  Busy;
    logic [31:0]           Perf_StallCycles;

    modport master (
        output ID_Valid, ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_IsMultiCycle,
               ID_BranchTaken, EX_MemRead, EX_DestReg,
        input  PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, Busy, Perf_StallCycles
    );

    modport slave (
        input  ID_Valid, ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_IsMultiCycle,
               ID_BranchTaken, EX_MemRead, EX_DestReg,
        output PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, Busy, Perf_StallCycles
    );

endinterface

// File: rtl/idex_hazard_ctrl_mc_timer.sv
// Loadable down-counter with a done flag; times the bubbles of a multi-cycle op.
module hazard_mc_timer #(
    parameter int CNT_W = 5
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;

    // Remaining-bubble counter: load on issue, count down while busy
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_count <= {CNT_W{1'b0}};
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != {CNT_W{1'b0}})) begin
            r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_done = (r_count == {CNT_W{1'b0}});

endmodule

// File: rtl/idex_hazard_ctrl.sv
// Load-use / multi-cycle / branch-flush controller for the IF/ID, PC and ID/EX registers.
// Optional stall counter enabled by defining STALL_PERF_COUNTER_EN.
module idex_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MC_LATENCY = HZ_MC_LATENCY_DEF,
    parameter int REG_ADDR_W = 5
) (
    input  logic         Clock,
    input  logic         Reset,
    idex_hazard_ctrl_if.slave hz
);

    localparam int CNT_W = $clog2(MC_LATENCY);

    hz_state_t r_state;
    logic      w_load_use;
    logic      w_mc_issue;
    logic      w_timer_done;
    logic      w_pc_write;
    logic      w_ifid_write;
    logic      w_ifid_flush;
    logic      w_idex_flush;
    logic      w_busy;

    assign w_load_use = hz.ID_Valid && hz.EX_MemRead
                     && (hz.EX_DestReg != REG_ADDR_W'(REG_ZERO))
                     && ((hz.ID_UsesRs && (hz.ID_Rs == hz.EX_DestReg))
                      || (hz.ID_UsesRt && (hz.ID_Rt == hz.EX_DestReg)));

    // Control decode; reset forces the free-running pipeline pattern
    always_comb begin
        w_pc_write   = 1'b1;
        w_ifid_write = 1'b1;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;
        w_busy       = 1'b0;
        w_mc_issue   = 1'b0;
        if (Reset) begin
            w_busy = 1'b0;
        end else if (r_state == HZ_MC_BUSY) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_idex_flush = 1'b1;
            w_busy       = 1'b1;
        end else if (w_load_use) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_idex_flush = 1'b1;
        end else if (hz.ID_Valid && hz.ID_IsMultiCycle) begin
            // A mult/div that also claims a taken branch is treated as mult/div only
            w_mc_issue = 1'b1;
        end else begin
            w_ifid_flush = hz.ID_BranchTaken;
        end
    end

    hazard_mc_timer #(.CNT_W(CNT_W)) u_mc_timer (
        .Clock      (Clock),
        .Reset      (Reset),
        .i_load     (w_mc_issue),
        .i_load_val (CNT_W'(MC_LATENCY - 2)),
        .i_dec      (r_state == HZ_MC_BUSY),
        .o_done     (w_timer_done)
    );

    // Controller FSM
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= HZ_IDLE;
        end else begin
            case (r_state)
                HZ_IDLE:    r_state <= w_mc_issue ? HZ_MC_BUSY : HZ_IDLE;
                HZ_MC_BUSY: r_state <= w_timer_done ? HZ_IDLE : HZ_MC_BUSY;
                default:    r_state <= HZ_IDLE;
            endcase
        end
    end

`ifdef STALL_PERF_COUNTER_EN
    logic [31:0] r_perf;

    // Saturating count of bubble cycles
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_perf <= 32'd0;
        end else if (w_idex_flush && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'd1;
        end else begin
            r_perf <= r_perf;
        end
    end

    assign hz.Perf_StallCycles = Reset ? 32'd0 : r_perf;
`else
    assign hz.Perf_StallCycles = 32'd0;
`endif

    assign hz.PC_Write   = w_pc_write;
    assign hz.IFID_Write = w_ifid_write;
    assign hz.IFID_Flush = w_ifid_flush;
    assign hz.IDEX_Flush = w_idex_flush;
    assign hz.Busy       = w_busy;

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// Bench for idex_hazard_ctrl: two instances (MC_LATENCY 4 and 32) share stimulus and
// are compared every cycle against a bubble-count model plus literal spot checks.
module tb_idex_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_mc;
    logic       id_br;
    logic       ex_memread;
    logic [4:0] ex_dest;

    int checks = 0;
    int errors = 0;

    idex_hazard_ctrl_if #(.REG_ADDR_W(5)) if4 ();
    idex_hazard_ctrl_if #(.REG_ADDR_W(5)) if32 ();

    assign if4.ID_Valid        = id_valid;
    assign if4.ID_Rs           = id_rs;
    assign if4.ID_Rt           = id_rt;
    assign if4.ID_UsesRs       = id_uses_rs;
    assign if4.ID_UsesRt       = id_uses_rt;
    assign if4.ID_IsMultiCycle = id_mc;
    assign if4.ID_BranchTaken  = id_br;
    assign if4.EX_MemRead      = ex_memread;
    assign if4.EX_DestReg      = ex_dest;
    assign if32.ID_Valid        = id_valid;
    assign if32.ID_Rs           = id_rs;
    assign if32.ID_Rt           = id_rt;
    assign if32.ID_UsesRs       = id_uses_rs;
    assign if32.ID_UsesRt       = id_uses_rt;
    assign if32.ID_IsMultiCycle = id_mc;
    assign if32.ID_BranchTaken  = id_br;
    assign if32.EX_MemRead      = ex_memread;
    assign if32.EX_DestReg      = ex_dest;

    idex_hazard_ctrl #(.MC_LATENCY(4), .REG_ADDR_W(5)) dut4 (
        .Clock (clk), .Reset (rst), .hz (if4)
    );
    idex_hazard_ctrl #(.MC_LATENCY(32), .REG_ADDR_W(5)) dut32 (
        .Clock (clk), .Reset (rst), .hz (if32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef STALL_PERF_COUNTER_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    // Model: bubbles still owed by an in-flight mult/div, and bubbles counted so far
    int bl4 = 0, bl32 = 0;
    longint perf4 = 0, perf32 = 0;

    function automatic bit load_use();
        return id_valid && ex_memread && (ex_dest != 5'd0)
            && ((id_uses_rs && id_rs == ex_dest) || (id_uses_rt && id_rt == ex_dest));
    endfunction

    // {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, Busy}
    function automatic logic [4:0] expect_ctl(input int bubbles);
        if (rst)                   return 5'b11000;
        if (bubbles > 0)           return 5'b00011;
        if (load_use())            return 5'b00010;
        if (id_valid && id_mc)     return 5'b11000;
        return {1'b1, 1'b1, id_br, 1'b0, 1'b0};
    endfunction

    function automatic int next_bl(input int bubbles, input int lat);
        if (rst)                              return 0;
        if (bubbles > 0)                      return bubbles - 1;
        if (!load_use() && id_valid && id_mc) return lat - 1;
        return 0;
    endfunction

    function automatic longint next_perf(input longint p, input logic [4:0] ctl);
        if (rst) return 0;
        if (ctl[1] && p < 64'h0000_0000_FFFF_FFFF) return p + 1;
        return p;
    endfunction

    // Model advance on each active edge using the inputs held through that cycle
    always @(posedge clk) begin
        perf4  <= next_perf(perf4,  expect_ctl(bl4));
        perf32 <= next_perf(perf32, expect_ctl(bl32));
        bl4    <= next_bl(bl4, 4);
        bl32   <= next_bl(bl32, 32);
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        logic [4:0] e4, e32;
        logic [4:0] a4, a32;
        e4  = expect_ctl(bl4);
        e32 = expect_ctl(bl32);
        a4  = {if4.PC_Write, if4.IFID_Write, if4.IFID_Flush, if4.IDEX_Flush, if4.Busy};
        a32 = {if32.PC_Write, if32.IFID_Write, if32.IFID_Flush, if32.IDEX_Flush, if32.Busy};
        cmp("ctl4", {27'd0, a4}, {27'd0, e4});
        cmp("ctl32", {27'd0, a32}, {27'd0, e32});
        cmp("perf4", if4.Perf_StallCycles, (PERF_ON && !rst) ? perf4[31:0] : 32'd0);
        cmp("perf32", if32.Perf_StallCycles, (PERF_ON && !rst) ? perf32[31:0] : 32'd0);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_mc = 1'b0; id_br = 1'b0; ex_memread = 1'b0; ex_dest = 5'd0;
    endtask

    initial begin
        int busy_cnt;
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        cmp("lit_reset_pc", {31'd0, if4.PC_Write}, 32'd1);
        cmp("lit_reset_busy", {31'd0, if32.Busy}, 32'd0);
        next_cycle();
        rst = 1'b0;

        // Load-use on Rs, then hazard gone
        id_valid = 1'b1; id_rs = 5'd8; id_uses_rs = 1'b1; ex_memread = 1'b1; ex_dest = 5'd8;
        @(negedge clk);
        cmp("lit_lu_idex_flush", {31'd0, if4.IDEX_Flush}, 32'd1);
        cmp("lit_lu_pc", {31'd0, if4.PC_Write}, 32'd0);
        next_cycle();
        ex_memread = 1'b0;
        @(negedge clk);
        cmp("lit_lu_after_pc", {31'd0, if4.PC_Write}, 32'd1);
        cmp("lit_lu_after_ifid", {31'd0, if4.IFID_Write}, 32'd1);
        next_cycle();

        // Load-use on Rt, and Valid=0 masking a matching compare
        idle_inputs();
        id_valid = 1'b1; id_rt = 5'd17; id_uses_rt = 1'b1; ex_memread = 1'b1; ex_dest = 5'd17;
        next_cycle();
        id_valid = 1'b0;
        @(negedge clk);
        cmp("lit_invalid_no_stall", {31'd0, if4.IDEX_Flush}, 32'd0);
        next_cycle();
        // Matching register but UsesRs=0
        id_valid = 1'b1; id_rs = 5'd17; id_rt = 5'd3;
        next_cycle();

        // Destination r0 never stalls
        idle_inputs();
        id_valid = 1'b1; id_rt = 5'd0; id_uses_rt = 1'b1; ex_memread = 1'b1; ex_dest = 5'd0;
        @(negedge clk);
        cmp("lit_r0_pc", {31'd0, if4.PC_Write}, 32'd1);
        cmp("lit_r0_idex", {31'd0, if4.IDEX_Flush}, 32'd0);
        next_cycle();

        // Taken branch during a load-use stall, then re-evaluated
        idle_inputs();
        id_valid = 1'b1; id_rs = 5'd9; id_uses_rs = 1'b1; id_br = 1'b1;
        ex_memread = 1'b1; ex_dest = 5'd9;
        @(negedge clk);
        cmp("lit_br_stall_flush", {31'd0, if4.IFID_Flush}, 32'd0);
        next_cycle();
        ex_memread = 1'b0;
        @(negedge clk);
        cmp("lit_br_after_flush", {31'd0, if4.IFID_Flush}, 32'd1);
        next_cycle();
        idle_inputs();

        // Multi-cycle op on the latency-4 instance, from a clean counter
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        id_valid = 1'b1; id_mc = 1'b1; id_br = 1'b1;
        @(negedge clk);
        cmp("lit_mc_issue_idex", {31'd0, if4.IDEX_Flush}, 32'd0);
        cmp("lit_mc_issue_ifidflush", {31'd0, if4.IFID_Flush}, 32'd0);
        cmp("lit_mc_issue_pc", {31'd0, if4.PC_Write}, 32'd1);
        next_cycle();
        idle_inputs();
        busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (if4.Busy === 1'b1 && if4.IDEX_Flush === 1'b1) busy_cnt++;
            next_cycle();
        end
        cmp("lit_mc4_bubbles", busy_cnt, 32'd3);
        @(negedge clk);
        cmp("lit_mc4_perf", if4.Perf_StallCycles, PERF_ON ? 32'd3 : 32'd0);
        cmp("lit_mc32_busy_still", {31'd0, if32.Busy}, 32'd1);
        next_cycle();

        // Reset in the middle of a latency-32 op
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        id_valid = 1'b1; id_mc = 1'b1;
        next_cycle();
        idle_inputs();
        repeat (5) next_cycle();
        @(negedge clk);
        cmp("lit_mc32_midop_busy", {31'd0, if32.Busy}, 32'd1);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        cmp("lit_rst_cycle_pc", {31'd0, if32.PC_Write}, 32'd1);
        cmp("lit_rst_cycle_busy", {31'd0, if32.Busy}, 32'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        cmp("lit_post_rst_busy", {31'd0, if32.Busy}, 32'd0);
        cmp("lit_post_rst_pc", {31'd0, if32.PC_Write}, 32'd1);
        cmp("lit_post_rst_perf", if32.Perf_StallCycles, 32'd0);
        next_cycle();

        // Back-to-back mult/div and branch traffic for the model to track
        id_valid = 1'b1; id_mc = 1'b1;
        next_cycle();
        id_mc = 1'b0; id_br = 1'b1;
        repeat (6) next_cycle();
        id_br = 1'b0;
        repeat (30) next_cycle();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
